// File: rtl/unum_pkg.sv
// Shared types and constants for the 32-bit posit (es=3) decode/encode path.
// unum_to_ieee is used by unum_decoder when UNUM_DECODER_IEEE_EN is defined.
package unum_pkg;

    localparam int UNUM_W       = 32;
    localparam int UNUM_ES      = 3;
    localparam int UNUM_FRAC_W  = 26;
    localparam int UNUM_SCALE_W = 9;

    localparam logic [UNUM_W-1:0] UNUM_NAR  = 32'h8000_0000;
    localparam logic [UNUM_W-1:0] UNUM_ZERO = 32'h0;

    typedef struct packed {
        logic                    sign;
        logic [UNUM_SCALE_W-1:0] scale;
        logic [UNUM_FRAC_W-1:0]  frac;
        logic                    is_zero;
        logic                    is_nar;
    } unum_fields_t;

    typedef struct packed {
        logic          sign;
        logic          is_zero;
        logic          is_nar;
        logic [UNUM_W-2:0] body;
    } unum_s1_t;

    typedef struct packed {
        logic                   sign;
        logic                   is_zero;
        logic                   is_nar;
        logic [5:0]             k;
        logic [UNUM_ES-1:0]     e;
        logic [UNUM_FRAC_W-1:0] frac;
    } unum_s2_t;

    // Saturates to max finite above the single range, flushes to zero below it.
    function automatic logic [31:0] unum_to_ieee(input unum_fields_t f);
        logic [31:0] res;
        logic [8:0]  bexp;
        bexp = f.scale + 9'd127;
        if (f.is_nar)
            res = 32'h7FC0_0000;
        else if (f.is_zero)
            res = 32'h0;
        else if ($signed(f.scale) > 9'sd127)
            res = {f.sign, 31'h7F7F_FFFF};
        else if ($signed(f.scale) < -9'sd126)
            res = {f.sign, 31'h0};
        else
            res = {f.sign, bexp[7:0], f.frac[25:3]};
        return res;
    endfunction

endpackage

// File: rtl/unum_regime_lzc.sv
// Regime run-length counter: length of the leading run of body[30]
// across the 31-bit posit body, built from 4-bit NLC groups.
module unum_regime_lzc (
    input  logic [30:0] body_i,
    output logic [4:0]  run_o,
    output logic        pol_o
);

    logic [31:0]      x;
    logic [7:0]       nz;
    logic [7:0][1:0]  pos;
    logic             found;

    assign pol_o = body_i[30];
    // Sentinel 1 in the LSB caps the count at 31 for an all-ones body.
    assign x = {body_i ^ {31{body_i[30]}}, 1'b1};

    genvar g;
    for (g = 0; g < 8; g++) begin : g_nlc
        logic [3:0] nib;
        assign nib    = x[31-4*g -: 4];
        assign nz[g]  = |nib;
        assign pos[g] = nib[3] ? 2'd0 :
                        nib[2] ? 2'd1 :
                        nib[1] ? 2'd2 : 2'd3;
    end

    always_comb begin
        run_o = {3'd7, pos[7]};
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && nz[i]) begin
                run_o = {3'(i), pos[i]};
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unum_decoder.sv
// 3-stage posit32 (es=3) decoder with valid/ready on both sides.
// UNUM_DECODER_IEEE_EN adds a registered IEEE-754 single output ieee_o.
module unum_decoder
    import unum_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [UNUM_W-1:0]       unum_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sign_o,
    output logic [UNUM_SCALE_W-1:0] scale_o,
    output logic [UNUM_FRAC_W-1:0]  frac_o,
    output logic                    is_zero_o,
    output logic                    is_nar_o
`ifdef UNUM_DECODER_IEEE_EN
    ,
    output logic [31:0]             ieee_o
`endif
);

    logic         adv;
    unum_s1_t     s1_d, s1_q;
    unum_s2_t     s2_d, s2_q;
    unum_fields_t out_d, out_q;
    logic         s1_v_q, s2_v_q, out_v_q;
    logic [4:0]   run;
    logic         pol;

    assign adv      = !out_v_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        s1_d         = '0;
        s1_d.sign    = unum_i[31];
        s1_d.is_zero = (unum_i == UNUM_ZERO);
        s1_d.is_nar  = (unum_i == UNUM_NAR);
        s1_d.body    = unum_i[31] ? ~unum_i[30:0] + 31'd1 : unum_i[30:0];
    end

    unum_regime_lzc u_lzc (
        .body_i (s1_q.body),
        .run_o  (run),
        .pol_o  (pol)
    );

    // Bits 30:29 always belong to the regime, so shift the rest by run-1.
    always_comb begin
        s2_d         = '0;
        s2_d.sign    = s1_q.sign;
        s2_d.is_zero = s1_q.is_zero;
        s2_d.is_nar  = s1_q.is_nar;
        s2_d.k       = pol ? {1'b0, run} - 6'd1 : 6'd0 - {1'b0, run};
        {s2_d.e, s2_d.frac} = s1_q.body[28:0] << (run - 5'd1);
    end

    always_comb begin
        out_d         = '0;
        out_d.is_zero = s2_q.is_zero;
        out_d.is_nar  = s2_q.is_nar;
        if (s2_q.is_nar) begin
            out_d.sign = 1'b1;
        end else if (!s2_q.is_zero) begin
            out_d.sign  = s2_q.sign;
            out_d.scale = {s2_q.k, s2_q.e};
            out_d.frac  = s2_q.frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            out_v_q <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            out_q   <= '0;
        end else if (adv) begin
            s1_v_q  <= in_valid;
            s2_v_q  <= s1_v_q;
            out_v_q <= s2_v_q;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_q   <= out_d;
        end
    end

`ifdef UNUM_DECODER_IEEE_EN
    logic [31:0] ieee_d, ieee_q;

    assign ieee_d = unum_to_ieee(out_d);

    always_ff @(posedge clk) begin
        if (rst)
            ieee_q <= '0;
        else if (adv)
            ieee_q <= ieee_d;
    end

    assign ieee_o = ieee_q;
`endif

    assign out_valid = out_v_q;
    assign sign_o    = out_q.sign;
    assign scale_o   = out_q.scale;
    assign frac_o    = out_q.frac;
    assign is_zero_o = out_q.is_zero;
    assign is_nar_o  = out_q.is_nar;

endmodule

// File: tb/tb_unum_decoder.sv
// Directed-vector bench for unum_decoder: decode values, latency,
// back-pressure and mid-stream reset.
module tb_unum_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] unum_i = '0;
    logic        in_ready, out_valid, sign_o, is_zero_o, is_nar_o;
    logic [8:0]  scale_o;
    logic [25:0] frac_o;
`ifdef UNUM_DECODER_IEEE_EN
    logic [31:0] ieee_o;
`endif

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] w;
        logic        s;
        logic [8:0]  sc;
        logic [25:0] fr;
        logic        z;
        logic        n;
        logic [31:0] ie;
    } vec_t;

    vec_t vecs[8];
    vec_t sv[5];

    unum_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .unum_i    (unum_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_o    (sign_o),
        .scale_o   (scale_o),
        .frac_o    (frac_o),
        .is_zero_o (is_zero_o),
        .is_nar_o  (is_nar_o)
`ifdef UNUM_DECODER_IEEE_EN
        ,
        .ieee_o    (ieee_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic chk_fields(input vec_t v);
        chk($sformatf("sign_%h", v.w), sign_o, v.s);
        chk($sformatf("scale_%h", v.w), scale_o, v.sc);
        chk($sformatf("frac_%h", v.w), frac_o, v.fr);
        chk($sformatf("zero_%h", v.w), is_zero_o, v.z);
        chk($sformatf("nar_%h", v.w), is_nar_o, v.n);
`ifdef UNUM_DECODER_IEEE_EN
        chk($sformatf("ieee_%h", v.w), ieee_o, v.ie);
`endif
    endtask

    task automatic decode_one(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1;
        unum_i   = v.w;
        #1 chk("in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        unum_i   = '0;
        @(negedge clk);
        chk($sformatf("early_%h", v.w), out_valid, 0);
        @(negedge clk);
        chk($sformatf("valid_%h", v.w), out_valid, 1);
        chk_fields(v);
    endtask

    initial begin
        vecs[0] = '{32'h4000_0000, 1'b0, 9'd0,   26'd0,        1'b0, 1'b0, 32'h3F80_0000};
        vecs[1] = '{32'hC000_0000, 1'b1, 9'd0,   26'd0,        1'b0, 1'b0, 32'hBF80_0000};
        vecs[2] = '{32'h4800_0000, 1'b0, 9'd2,   26'd0,        1'b0, 1'b0, 32'h4080_0000};
        vecs[3] = '{32'h7FFF_FFFF, 1'b0, 9'd240, 26'd0,        1'b0, 1'b0, 32'h7F7F_FFFF};
        vecs[4] = '{32'h0000_0001, 1'b0, 9'h110, 26'd0,        1'b0, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h3FFF_FFFF, 1'b0, 9'h1FF, 26'h3FF_FFFF, 1'b0, 1'b0, 32'h3F7F_FFFF};
        vecs[6] = '{32'h0000_0000, 1'b0, 9'd0,   26'd0,        1'b1, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h8000_0000, 1'b1, 9'd0,   26'd0,        1'b0, 1'b1, 32'h7FC0_0000};
        sv[0] = vecs[0];
        sv[1] = vecs[2];
        sv[2] = vecs[3];
        sv[3] = vecs[5];
        sv[4] = vecs[1];

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sign", sign_o, 0);
        chk("rst_scale", scale_o, 0);
        chk("rst_frac", frac_o, 0);
        chk("rst_zero", is_zero_o, 0);
        chk("rst_nar", is_nar_o, 0);

        for (int i = 0; i < 8; i++)
            decode_one(vecs[i]);

        begin
            int idx = 0;
            int got = 0;
            int stalls = 0;
            for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
                @(negedge clk);
                out_ready = !(cyc >= 2 && cyc < 6);
                in_valid  = (idx < 5);
                unum_i    = (idx < 5) ? sv[idx].w : 32'h0;
                #1;
                if (out_valid) begin
                    if (got < 5)
                        chk_fields(sv[got]);
                    if (!out_ready) begin
                        stalls++;
                        chk("stall_in_ready", in_ready, 0);
                    end else begin
                        got++;
                    end
                end
                if (in_valid && in_ready)
                    idx++;
            end
            chk("stream_emitted", got, 5);
            chk("stream_accepted", idx, 5);
            chk("stream_stalls", stalls, 3);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (4) begin
                @(negedge clk);
                chk("stream_no_dup", out_valid, 0);
            end
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            unum_i   = vecs[i].w;
        end
        @(negedge clk);
        in_valid = 1'b0;
        unum_i   = '0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("midrst_dropped", out_valid, 0);
        end
        decode_one(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
